rv_fetch_ctrl: RTL and testbench

Instruction fetch controller for the rv core. It owns the fetch address and drives a request/grant/response instruction-memory port. It buffers returned words with their addresses in a small in-order FIFO and hands them to the decoder over a valid/ready handshake. It also redirects fetch on taken branches, discarding any stale responses still in flight.

---
 rtl/rv_pkg.sv | 16 +
 rtl/rv_fetch_fifo.sv | 63 ++++++
 rtl/rv_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_rv_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared fetch types and constants for the rv core
package rv_pkg;

    localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic {
        FETCH_BOOT,
        FETCH_RUN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// rtl/rv_fetch_fifo.sv - in-order buffer of fetched words with their addresses
module rv_fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     wdata,
    input  logic             pop,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign do_pop  = pop & !empty & !flush;
    assign do_push = push & !flush & (!full | do_pop);

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = mem[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv_fetch_ctrl.sv
// rtl/rv_fetch_ctrl.sv - instruction fetch controller with redirect and stale-response discard
module rv_fetch_ctrl
    import rv_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        halt_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [31:0]      fetch_addr;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] out_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   inflight;
    logic             halt_q;
    logic [31:0]      tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tag_wptr;
    logic [PTR_W-1:0] tag_rptr;
    logic             gnt;
    logic             rsp;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    fetch_entry_t     wentry;
    fetch_entry_t     head;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Request gating sees only flops, so no input reaches mem_req_o combinationally.
    always_comb begin
        state_d   = state_q;
        mem_req_o = 1'b0;
        case (state_q)
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN:  mem_req_o = !halt_q && (inflight < (CNT_W + 1)'(FIFO_DEPTH));
            default:    state_d = FETCH_BOOT;
        endcase
    end

    assign inflight   = {1'b0, count} + {1'b0, outstanding};
    assign mem_addr_o = fetch_addr;
    assign gnt        = mem_req_o & mem_gnt_i;
    assign rsp        = mem_rvalid_i & (outstanding != '0);
    assign out_next   = outstanding + CNT_W'(gnt) - CNT_W'(rsp);
    assign push       = rsp & (discard == '0) & !redirect_i & (!fifo_full | pop);
    assign pop        = instr_valid_o & instr_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr  <= BOOT_ADDR;
            outstanding <= '0;
            discard     <= '0;
            halt_q      <= 1'b0;
            tag_wptr    <= '0;
            tag_rptr    <= '0;
        end else begin
            halt_q      <= halt_i;
            outstanding <= out_next;
            if (redirect_i) begin
                fetch_addr <= redirect_addr_i & FETCH_ALIGN_MASK;
                discard    <= out_next;
            end else begin
                if (gnt) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (rsp && discard != '0) begin
                    discard <= discard - 1'b1;
                end
            end
            // Tags track every granted request, including ones later discarded.
            if (gnt) begin
                tag_wptr <= (tag_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : tag_wptr + 1'b1;
            end
            if (rsp) begin
                tag_rptr <= (tag_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : tag_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt) begin
            tag_mem[tag_wptr] <= fetch_addr;
        end
    end

    assign wentry.instr = mem_rdata_i;
    assign wentry.addr  = tag_mem[tag_rptr];

    rv_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush  (redirect_i),
        .push   (push),
        .wdata  (wentry),
        .pop    (pop),
        .rdata  (head),
        .count  (count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head.instr;
    assign instr_addr_o  = head.addr;

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// tb/tb_rv_fetch_ctrl.sv - directed self-checking bench for rv_fetch_ctrl
module tb_rv_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        halt_i;

    int          errors = 0;
    int          checks = 0;
    int          gcount = 0;
    int          g0;
    int          n;
    logic        gnt_en;
    logic        rsp_en;
    logic [31:0] pend [$];

    rv_fetch_ctrl #(
        .BOOT_ADDR  (32'h0000_0100),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_addr_o    (instr_addr_o),
        .instr_ready_i   (instr_ready_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .halt_i          (halt_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: grants at gnt_en level, answers in order one cycle after grant with ~addr.
    task automatic tick();
        logic        g;
        logic        r;
        logic [31:0] a;
        g = mem_req_o & mem_gnt_i;
        r = mem_rvalid_i;
        a = mem_addr_o;
        @(posedge clk_i);
        #1;
        if (r && pend.size() > 0) void'(pend.pop_front());
        if (g) begin
            pend.push_back(a);
            gcount++;
        end
        mem_rvalid_i = rsp_en && (pend.size() > 0);
        mem_rdata_i  = mem_rvalid_i ? ~pend[0] : 32'h0;
        mem_gnt_i    = gnt_en;
        redirect_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        rst_ni          = 1'b0;
        gnt_en          = 1'b1;
        rsp_en          = 1'b1;
        mem_gnt_i       = 1'b1;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = 32'h0;
        instr_ready_i   = 1'b1;
        redirect_i      = 1'b0;
        redirect_addr_i = 32'h0;
        halt_i          = 1'b0;
        #12;
        chk("rst_req",   {31'h0, mem_req_o},     32'h0);
        chk("rst_addr",  mem_addr_o,             32'h100);
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_instr", instr_o,                32'h0);
        chk("rst_iaddr", instr_addr_o,           32'h0);

        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("boot_noreq", {31'h0, mem_req_o}, 32'h0);
        tick();
        chk("req0", {31'h0, mem_req_o}, 32'h1);
        chk("req0_addr", mem_addr_o, 32'h100);
        tick();
        chk("req1", {31'h0, mem_req_o}, 32'h1);
        chk("req1_addr", mem_addr_o, 32'h104);
        chk("no_bypass", {31'h0, instr_valid_o}, 32'h0);
        tick();
        chk("first_valid", {31'h0, instr_valid_o}, 32'h1);
        chk("first_iaddr", instr_addr_o, 32'h100);
        chk("first_instr", instr_o, ~32'h100);
        tick();
        chk("req2_addr", mem_addr_o, 32'h108);
        chk("second_iaddr", instr_addr_o, 32'h104);
        chk("second_instr", instr_o, ~32'h104);

        // Halt mid-stream: the 0x108 grant in this cycle still delivers.
        halt_i = 1'b1;
        tick();
        chk("halt_noreq", {31'h0, mem_req_o}, 32'h0);
        tick();
        chk("halt_inflight_valid", {31'h0, instr_valid_o}, 32'h1);
        chk("halt_inflight_iaddr", instr_addr_o, 32'h108);
        chk("halt_noreq2", {31'h0, mem_req_o}, 32'h0);
        tick();
        instr_ready_i = 1'b0;
        halt_i        = 1'b0;
        chk("unhalt_lag", {31'h0, mem_req_o}, 32'h0);
        tick();
        chk("resume_req", {31'h0, mem_req_o}, 32'h1);
        chk("resume_addr", mem_addr_o, 32'h10C);

        g0 = gcount;
        for (int i = 0; i < 6; i++) tick();
        chk("fill_grants", gcount - g0, 32'd2);
        chk("fill_noreq", {31'h0, mem_req_o}, 32'h0);
        chk("fill_head", instr_addr_o, 32'h10C);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        chk("pop_req_addr", mem_addr_o, 32'h114);
        for (int i = 0; i < 6; i++) tick();
        chk("pop_one_grant", gcount - g0, 32'd3);
        chk("pop_noreq", {31'h0, mem_req_o}, 32'h0);
        chk("pop_head", instr_addr_o, 32'h110);

        // Drain, then build two outstanding requests with responses held back.
        rsp_en        = 1'b0;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("os2_noreq", {31'h0, mem_req_o}, 32'h0);
        chk("os2_empty", {31'h0, instr_valid_o}, 32'h0);
        rsp_en          = 1'b1;
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h2003;
        tick();
        chk("redir_valid0", {31'h0, instr_valid_o}, 32'h0);
        chk("redir_addr", mem_addr_o, 32'h2000);
        chk("redir_credit_wait", {31'h0, mem_req_o}, 32'h0);
        tick();
        chk("redir_req", {31'h0, mem_req_o}, 32'h1);
        chk("redir_req_addr", mem_addr_o, 32'h2000);
        n = 0;
        while (!instr_valid_o && n < 10) begin
            tick();
            n++;
        end
        chk("redir_deliver", {31'h0, instr_valid_o}, 32'h1);
        chk("redir_first_iaddr", instr_addr_o, 32'h2000);
        chk("redir_first_instr", instr_o, ~32'h2000);

        // Redirect coinciding with both a grant and a response.
        n = 0;
        while (!(mem_req_o && mem_gnt_i && mem_rvalid_i) && n < 20) begin
            tick();
            n++;
        end
        chk("triple_found", {31'h0, mem_req_o & mem_gnt_i & mem_rvalid_i}, 32'h1);
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h3000;
        tick();
        chk("triple_valid0", {31'h0, instr_valid_o}, 32'h0);
        n = 0;
        while (!instr_valid_o && n < 10) begin
            tick();
            n++;
        end
        chk("triple_deliver", {31'h0, instr_valid_o}, 32'h1);
        chk("triple_first_iaddr", instr_addr_o, 32'h3000);

        // Address wrap at the top of the address space.
        redirect_i      = 1'b1;
        redirect_addr_i = 32'hFFFF_FFFF;
        tick();
        n = 0;
        while (!mem_req_o && n < 10) begin
            tick();
            n++;
        end
        chk("wrap_req_top", mem_addr_o, 32'hFFFF_FFFC);
        tick();
        n = 0;
        while (!mem_req_o && n < 10) begin
            tick();
            n++;
        end
        chk("wrap_req_zero", mem_addr_o, 32'h0000_0000);

        // Asynchronous reset with a full buffer.
        instr_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("full_pre_valid", {31'h0, instr_valid_o}, 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("arst_req", {31'h0, mem_req_o}, 32'h0);
        chk("arst_iaddr", instr_addr_o, 32'h0);
        chk("arst_addr", mem_addr_o, 32'h100);
        pend.delete();
        mem_rvalid_i  = 1'b0;
        instr_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("reboot_noreq", {31'h0, mem_req_o}, 32'h0);
        tick();
        chk("reboot_req", {31'h0, mem_req_o}, 32'h1);
        chk("reboot_addr", mem_addr_o, 32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
